regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
Shares the register file's single write port between two writeback requesters, EXU results and LSU load data, using round-robin arbitration with valid/ready handshakes. A one-entry registered output stage drives the register file write port.
A per-register pending-write scoreboard gates instruction issue so that no instruction reads a source register with an outstanding write (RAW hazard).
Sits between issue/EXU/LSU and the register file; it drives the register file's wdata/waddr/wen/valid inputs directly.

Parameters:
ADDR_WIDTH, 5, register index width; register count is 2**ADDR_WIDTH.
DATA_WIDTH, 32, register data width.
CNT_WIDTH, 2, width of each pending-write counter; saturates at 2**CNT_WIDTH-1.

Ports:
i_clock  in  1  clock; all state updates on posedge.
i_reset  in  1  synchronous, active-high reset.
i_exu_valid  in  1  EXU writeback request.
o_exu_ready  out  1  EXU request accepted this cycle.
i_exu_wen  in  1  EXU instruction writes rd.
i_exu_waddr  in  ADDR_WIDTH  EXU rd.
i_exu_wdata  in  DATA_WIDTH  EXU result.
i_lsu_valid  in  1  LSU writeback request.
o_lsu_ready  out  1  LSU request accepted this cycle.
i_lsu_wen  in  1  LSU instruction writes rd.
i_lsu_waddr  in  ADDR_WIDTH  LSU rd.
i_lsu_wdata  in  DATA_WIDTH  LSU load data.
i_issue_valid  in  1  issue stage presents an instruction.
o_issue_ready  out  1  instruction may issue (no hazard, rd counter not saturated).
i_issue_wen  in  1  issuing instruction will write rd.
i_issue_rd  in  ADDR_WIDTH  destination register.
i_issue_rs1  in  ADDR_WIDTH  source register 1.
i_issue_rs2  in  ADDR_WIDTH  source register 2.
o_rf_valid  out  1  output stage holds an entry; drives register file valid.
o_rf_wen  out  1  write enable to register file.
o_rf_waddr  out  ADDR_WIDTH  write address.
o_rf_wdata  out  DATA_WIDTH  write data.

Behaviour:
- Reset: all pending counters = 0; o_rf_valid = o_rf_wen = 0; o_rf_waddr = o_rf_wdata = 0; round-robin pointer = EXU. Reset mid-operation drops any in-flight entry, so no write occurs in the cycle after reset.
- Arbitration: combinational, and the output stage is always free (the register file accepts every cycle).
  - Only one requester valid: that requester gets ready = 1.
  - Both valid: the requester selected by the pointer wins. After a contested grant the pointer moves to the loser; an uncontested grant leaves it unchanged.
  - ready is never asserted without the corresponding valid.
- Output stage latency: a request accepted in cycle N appears on o_rf_* in cycle N+1 and writes at the posedge ending N+1.
  - o_rf_valid = 1 in N+1.
  - o_rf_wen = accepted wen AND waddr != 0.
  - With no acceptance in N, o_rf_valid = o_rf_wen = 0 in N+1; waddr/wdata hold their last values.
- Scoreboard counter updates:
  - Issue handshake (i_issue_valid && o_issue_ready) with i_issue_wen && rd != 0: increments cnt[rd].
  - Output stage with o_rf_wen = 1: decrements cnt[o_rf_waddr] at the same edge the register file writes.
  - Increment and decrement of the same register in the same cycle: net unchanged.
  - Decrement at 0 is a protocol violation; the counter stays at 0 and a simulation assertion fires.
- o_issue_ready (combinational): 0 when any of the following holds, else 1. Register x0 never stalls.
  - rs1 != 0 and cnt[rs1] != 0.
  - rs2 != 0 and cnt[rs2] != 0.
  - i_issue_wen and rd != 0 and cnt[rd] == max.
- No bypass: a source whose write occurs at the edge ending cycle N+1 may issue in N+2 at the earliest. A pending decrement in the current cycle does not release the stall combinationally.
- Requests with wen = 0 or waddr = 0 are accepted normally, produce o_rf_wen = 0 and leave counters unchanged.

Decomposition:
- Shared package:
  - ADDR_WIDTH/DATA_WIDTH defaults.
  - Requester index enum (REQ_EXU = 0, REQ_LSU = 1).
  - Writeback request struct (wen, waddr, wdata).
- Sub-module regfile_scoreboard: counter array, increment/decrement/saturation logic and hazard check. The arbiter and output stage stay in the top module.

Test Plan:
- Reset then idle → o_rf_valid = 0; o_issue_ready = 1 for rs1 = 3, rs2 = 4.
- Issue rd = 5 wen = 1; next cycle issue rs1 = 5 → o_issue_ready = 0. Then EXU writes x5 = 0xDEADBEEF:
  - o_exu_ready = 1 in cycle N.
  - o_rf_wen = 1, waddr = 5, wdata = 0xDEADBEEF in N+1.
  - o_issue_ready = 1 from N+2.
- EXU and LSU both valid for 4 consecutive cycles from reset → grants EXU, LSU, EXU, LSU; o_rf_waddr follows in order one cycle later.
- Issue rd = 7 three times with CNT_WIDTH = 2 → cnt = 3; fourth issue rd = 7 → o_issue_ready = 0 until one write to x7 completes.
- Same cycle: issue rd = 9 plus output-stage write of x9 with cnt[9] = 1 → cnt[9] stays 1; rs1 = 9 remains stalled.
- LSU request waddr = 0 wdata = 0x1234 → accepted, o_rf_valid = 1, o_rf_wen = 0, no counter change. Reset asserted in the acceptance cycle → o_rf_valid = 0 next cycle.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types and default sizes for the register file writeback scheduler.
package regfile_wb_scheduler_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF  = 2;

  // Writeback requester index; also the encoding of the round-robin pointer.
  typedef enum logic {
    REQ_EXU = 1'b0,
    REQ_LSU = 1'b1
  } req_idx_e;

  // Writeback request at default widths, for agents sitting around the block.
  typedef struct packed {
    logic                      wen;
    logic [ADDR_WIDTH_DEF-1:0] waddr;
    logic [DATA_WIDTH_DEF-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// Per-register pending-write counters and RAW / saturation issue gating.
// The issue side increments the destination's counter, the register file
// write decrements it, and a source with a nonzero counter holds issue.
module regfile_wb_scheduler_scoreboard
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_issue_valid,
  input  logic                  i_issue_wen,
  input  logic [ADDR_WIDTH-1:0] i_issue_rd,
  input  logic [ADDR_WIDTH-1:0] i_issue_rs1,
  input  logic [ADDR_WIDTH-1:0] i_issue_rs2,
  output logic                  o_issue_ready,
  input  logic                  i_dec_en,
  input  logic [ADDR_WIDTH-1:0] i_dec_addr
);

  localparam int                   NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [NUM_REGS-1:0][CNT_WIDTH-1:0] cnt;
  logic [NUM_REGS-1:0][CNT_WIDTH-1:0] cnt_nxt;
  logic                               rs1_busy, rs2_busy, rd_full;
  logic                               inc_en;

  // Hazard check: only registered counter state is used, so a write landing
  // this cycle releases its readers one cycle later (no bypass).
  always_comb begin
    rs1_busy      = (i_issue_rs1 != '0) && (cnt[i_issue_rs1] != '0);
    rs2_busy      = (i_issue_rs2 != '0) && (cnt[i_issue_rs2] != '0);
    rd_full       = i_issue_wen && (i_issue_rd != '0) && (cnt[i_issue_rd] == CNT_MAX);
    o_issue_ready = ~(rs1_busy | rs2_busy | rd_full);
    inc_en        = i_issue_valid && o_issue_ready && i_issue_wen && (i_issue_rd != '0);
  end

  // Next counter values; a simultaneous increment and decrement cancel.
  always_comb begin
    cnt_nxt = cnt;
    for (int r = 0; r < NUM_REGS; r++) begin
      logic inc_hit, dec_hit;
      inc_hit = inc_en   && (i_issue_rd == ADDR_WIDTH'(r));
      dec_hit = i_dec_en && (i_dec_addr == ADDR_WIDTH'(r));
      if (inc_hit && !dec_hit && (cnt[r] != CNT_MAX))
        cnt_nxt[r] = cnt[r] + 1'b1;
      else if (dec_hit && !inc_hit && (cnt[r] != '0))
        cnt_nxt[r] = cnt[r] - 1'b1;
    end
  end

  // Counter array register.
  always_ff @(posedge i_clock) begin
    if (i_reset) cnt <= '0;
    else         cnt <= cnt_nxt;
  end

  // A write retiring a register with nothing pending means the requesters
  // broke protocol; the counter is clamped at zero above.
  always_ff @(posedge i_clock) begin
    if (!i_reset && i_dec_en)
      assert (cnt[i_dec_addr] != '0)
        else $error("scoreboard underflow on x%0d", i_dec_addr);
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Round-robin share of the register file write port between EXU and LSU
// writeback, a one-entry registered write stage, and the pending-write
// scoreboard that gates instruction issue.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_exu_valid,
  output logic                  o_exu_ready,
  input  logic                  i_exu_wen,
  input  logic [ADDR_WIDTH-1:0] i_exu_waddr,
  input  logic [DATA_WIDTH-1:0] i_exu_wdata,
  input  logic                  i_lsu_valid,
  output logic                  o_lsu_ready,
  input  logic                  i_lsu_wen,
  input  logic [ADDR_WIDTH-1:0] i_lsu_waddr,
  input  logic [DATA_WIDTH-1:0] i_lsu_wdata,
  input  logic                  i_issue_valid,
  output logic                  o_issue_ready,
  input  logic                  i_issue_wen,
  input  logic [ADDR_WIDTH-1:0] i_issue_rd,
  input  logic [ADDR_WIDTH-1:0] i_issue_rs1,
  input  logic [ADDR_WIDTH-1:0] i_issue_rs2,
  output logic                  o_rf_valid,
  output logic                  o_rf_wen,
  output logic [ADDR_WIDTH-1:0] o_rf_waddr,
  output logic [DATA_WIDTH-1:0] o_rf_wdata
);

  // Same layout as wb_req_t, sized by this instance's parameters.
  typedef struct packed {
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_t     exu_req, lsu_req, win_req;
  req_idx_e rr_ptr;
  logic     contested, exu_gnt, lsu_gnt, accept;

  assign exu_req = '{wen: i_exu_wen, waddr: i_exu_waddr, wdata: i_exu_wdata};
  assign lsu_req = '{wen: i_lsu_wen, waddr: i_lsu_waddr, wdata: i_lsu_wdata};

  // Grant: a lone requester always wins; on contention the pointer decides.
  // The write stage drains every cycle, so any request can be accepted.
  always_comb begin
    contested   = i_exu_valid & i_lsu_valid;
    exu_gnt     = i_exu_valid & (~i_lsu_valid | (rr_ptr == REQ_EXU));
    lsu_gnt     = i_lsu_valid & (~i_exu_valid | (rr_ptr == REQ_LSU));
    accept      = exu_gnt | lsu_gnt;
    win_req     = exu_gnt ? exu_req : lsu_req;
    o_exu_ready = exu_gnt;
    o_lsu_ready = lsu_gnt;
  end

  // Round-robin pointer: only a contested grant hands priority to the loser.
  always_ff @(posedge i_clock) begin
    if (i_reset)        rr_ptr <= REQ_EXU;
    else if (contested) rr_ptr <= exu_gnt ? REQ_LSU : REQ_EXU;
  end

  // Write stage: one entry, refilled every cycle. Address/data hold when idle
  // so the register file sees stable values; x0 writes are suppressed here.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_rf_valid <= 1'b0;
      o_rf_wen   <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
    end else begin
      o_rf_valid <= accept;
      o_rf_wen   <= accept & win_req.wen & (win_req.waddr != '0);
      if (accept) begin
        o_rf_waddr <= win_req.waddr;
        o_rf_wdata <= win_req.wdata;
      end
    end
  end

  // The counter is released at the same edge the register file is written.
  regfile_wb_scheduler_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_scoreboard (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_issue_valid (i_issue_valid),
    .i_issue_wen   (i_issue_wen),
    .i_issue_rd    (i_issue_rd),
    .i_issue_rs1   (i_issue_rs1),
    .i_issue_rs2   (i_issue_rs2),
    .o_issue_ready (o_issue_ready),
    .i_dec_en      (o_rf_wen),
    .i_dec_addr    (o_rf_waddr)
  );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed scenarios followed by random traffic, all checked every cycle
// against a count-per-register model of pending writes.
module tb_regfile_wb_scheduler;
  import regfile_wb_scheduler_pkg::*;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NR   = 32;
  localparam int CMAX = 3;

  logic          i_clock, i_reset;
  logic          i_exu_valid, o_exu_ready, i_exu_wen;
  logic [AW-1:0] i_exu_waddr;
  logic [DW-1:0] i_exu_wdata;
  logic          i_lsu_valid, o_lsu_ready, i_lsu_wen;
  logic [AW-1:0] i_lsu_waddr;
  logic [DW-1:0] i_lsu_wdata;
  logic          i_issue_valid, o_issue_ready, i_issue_wen;
  logic [AW-1:0] i_issue_rd, i_issue_rs1, i_issue_rs2;
  logic          o_rf_valid, o_rf_wen;
  logic [AW-1:0] o_rf_waddr;
  logic [DW-1:0] o_rf_wdata;

  regfile_wb_scheduler dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_exu_valid(i_exu_valid), .o_exu_ready(o_exu_ready), .i_exu_wen(i_exu_wen),
    .i_exu_waddr(i_exu_waddr), .i_exu_wdata(i_exu_wdata),
    .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready), .i_lsu_wen(i_lsu_wen),
    .i_lsu_waddr(i_lsu_waddr), .i_lsu_wdata(i_lsu_wdata),
    .i_issue_valid(i_issue_valid), .o_issue_ready(o_issue_ready), .i_issue_wen(i_issue_wen),
    .i_issue_rd(i_issue_rd), .i_issue_rs1(i_issue_rs1), .i_issue_rs2(i_issue_rs2),
    .o_rf_valid(o_rf_valid), .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int n_vec, n_err;

  // Reference model: pending writes per register, who has priority, and what
  // the write stage should show.
  int            cnt_m[NR];
  int            avail[NR];     // issued writes not yet handed to a requester
  bit            rr_lsu;
  bit            exp_v, exp_w;
  logic [AW-1:0] exp_a;
  logic [DW-1:0] exp_d;
  bit            e_exu, e_lsu, e_iss;

  // Random requester holds: a request stays valid until granted.
  bit      exu_h, lsu_h;
  wb_req_t exu_r, lsu_r;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void predict();
    e_iss = 1'b1;
    if (i_issue_rs1 != 0 && cnt_m[i_issue_rs1] > 0) e_iss = 1'b0;
    if (i_issue_rs2 != 0 && cnt_m[i_issue_rs2] > 0) e_iss = 1'b0;
    if (i_issue_wen && i_issue_rd != 0 && cnt_m[i_issue_rd] == CMAX) e_iss = 1'b0;
    e_exu = i_exu_valid && (!i_lsu_valid || !rr_lsu);
    e_lsu = i_lsu_valid && (!i_exu_valid || rr_lsu);
  endfunction

  // Mid-cycle: compare every output against the model.
  task automatic settle();
    #3;
    predict();
    chk("exu_ready",   {31'd0, o_exu_ready},   {31'd0, e_exu});
    chk("lsu_ready",   {31'd0, o_lsu_ready},   {31'd0, e_lsu});
    chk("issue_ready", {31'd0, o_issue_ready}, {31'd0, e_iss});
    chk("rf_valid",    {31'd0, o_rf_valid},    {31'd0, exp_v});
    chk("rf_wen",      {31'd0, o_rf_wen},      {31'd0, exp_w});
    chk("rf_waddr",    {27'd0, o_rf_waddr},    {27'd0, exp_a});
    chk("rf_wdata",    o_rf_wdata,             exp_d);
  endtask

  // Clock edge: advance the model with the inputs that were just sampled.
  task automatic adv();
    predict();
    @(posedge i_clock);
    if (i_reset) begin
      for (int r = 0; r < NR; r++) begin cnt_m[r] = 0; avail[r] = 0; end
      rr_lsu = 0; exp_v = 0; exp_w = 0; exp_a = '0; exp_d = '0;
      exu_h = 0; lsu_h = 0;
    end else begin
      if (exp_w && cnt_m[exp_a] > 0) cnt_m[exp_a]--;
      if (i_issue_valid && e_iss && i_issue_wen && i_issue_rd != 0) begin
        cnt_m[i_issue_rd]++;
        avail[i_issue_rd]++;
      end
      if (i_exu_valid && i_lsu_valid) rr_lsu = e_exu;
      if (e_exu) begin
        exp_v = 1; exp_w = i_exu_wen && (i_exu_waddr != 0); exp_a = i_exu_waddr; exp_d = i_exu_wdata;
        exu_h = 0;
      end else if (e_lsu) begin
        exp_v = 1; exp_w = i_lsu_wen && (i_lsu_waddr != 0); exp_a = i_lsu_waddr; exp_d = i_lsu_wdata;
        lsu_h = 0;
      end else begin
        exp_v = 0; exp_w = 0;
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  task automatic gen(output bit h, output wb_req_t r);
    int k, s, reg_i;
    h = 0;
    r = '0;
    if ($urandom_range(0, 1) == 0) return;
    h = 1;
    r.wdata = $urandom;
    k = $urandom_range(0, 3);
    if (k == 0) begin
      r.wen = 0; r.waddr = AW'($urandom_range(0, NR-1));
    end else if (k == 1) begin
      r.wen = 1; r.waddr = '0;
    end else begin
      r.wen = 0; r.waddr = AW'($urandom_range(1, 7));
      s = $urandom_range(0, 6);
      for (int i = 0; i < 7; i++) begin
        reg_i = 1 + ((s + i) % 7);
        if (avail[reg_i] > 0) begin
          avail[reg_i]--;
          r.wen = 1; r.waddr = AW'(reg_i);
          break;
        end
      end
    end
  endtask

  task automatic idle_inputs();
    i_exu_valid = 0; i_exu_wen = 0; i_exu_waddr = '0; i_exu_wdata = '0;
    i_lsu_valid = 0; i_lsu_wen = 0; i_lsu_waddr = '0; i_lsu_wdata = '0;
    i_issue_valid = 0; i_issue_wen = 0; i_issue_rd = '0; i_issue_rs1 = '0; i_issue_rs2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_reset = 1;
    cyc();
    i_reset = 0;
  endtask

  initial begin
    logic [AW-1:0] prev_a;
    n_vec = 0; n_err = 0;
    exu_h = 0; lsu_h = 0;
    idle_inputs();
    i_reset = 1;
    @(posedge i_clock); #1;
    adv();
    adv();
    i_reset = 0;

    // Reset then idle
    i_issue_rs1 = 5'd3; i_issue_rs2 = 5'd4;
    settle();
    chk("t1_rf_valid", {31'd0, o_rf_valid}, 32'd0);
    chk("t1_issue_ok", {31'd0, o_issue_ready}, 32'd1);
    adv();

    // RAW on x5, released two cycles after the EXU write is accepted
    i_issue_valid = 1; i_issue_wen = 1; i_issue_rd = 5'd5; i_issue_rs1 = '0; i_issue_rs2 = '0;
    cyc();
    i_issue_wen = 0; i_issue_rd = '0; i_issue_rs1 = 5'd5;
    i_exu_valid = 1; i_exu_wen = 1; i_exu_waddr = 5'd5; i_exu_wdata = 32'hDEADBEEF;
    settle();
    chk("t2_stall", {31'd0, o_issue_ready}, 32'd0);
    chk("t2_exu_gnt", {31'd0, o_exu_ready}, 32'd1);
    adv();
    i_exu_valid = 0;
    settle();
    chk("t2_rf_wen", {31'd0, o_rf_wen}, 32'd1);
    chk("t2_rf_waddr", {27'd0, o_rf_waddr}, 32'd5);
    chk("t2_rf_wdata", o_rf_wdata, 32'hDEADBEEF);
    chk("t2_no_bypass", {31'd0, o_issue_ready}, 32'd0);
    adv();
    settle();
    chk("t2_release", {31'd0, o_issue_ready}, 32'd1);
    adv();

    // Round robin under continuous contention from reset
    do_reset();
    prev_a = '0;
    for (int c = 0; c < 4; c++) begin
      i_exu_valid = 1; i_exu_wen = 0; i_exu_waddr = AW'(16 + c); i_exu_wdata = 32'(c);
      i_lsu_valid = 1; i_lsu_wen = 0; i_lsu_waddr = AW'(20 + c); i_lsu_wdata = 32'(100 + c);
      settle();
      chk("t3_exu_gnt", {31'd0, o_exu_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_lsu_gnt", {31'd0, o_lsu_ready}, (c % 2 == 1) ? 32'd1 : 32'd0);
      if (c > 0) chk("t3_order", {27'd0, o_rf_waddr}, {27'd0, prev_a});
      prev_a = (c % 2 == 0) ? AW'(16 + c) : AW'(20 + c);
      adv();
    end
    idle_inputs();
    settle();
    chk("t3_order_last", {27'd0, o_rf_waddr}, {27'd0, prev_a});
    adv();

    // Saturation of x7's counter
    do_reset();
    i_issue_valid = 1; i_issue_wen = 1; i_issue_rd = 5'd7;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t4_issue_ok", {31'd0, o_issue_ready}, 32'd1);
      adv();
    end
    settle();
    chk("t4_saturated", {31'd0, o_issue_ready}, 32'd0);
    adv();
    i_exu_valid = 1; i_exu_wen = 1; i_exu_waddr = 5'd7; i_exu_wdata = 32'h0000_0777;
    settle();
    chk("t4_sat_hold", {31'd0, o_issue_ready}, 32'd0);
    adv();
    i_exu_valid = 0;
    settle();
    chk("t4_wr_x7", {31'd0, o_rf_wen}, 32'd1);
    chk("t4_sat_hold2", {31'd0, o_issue_ready}, 32'd0);
    adv();
    settle();
    chk("t4_unsat", {31'd0, o_issue_ready}, 32'd1);
    adv();

    // Same-edge increment and decrement of x9
    do_reset();
    i_issue_valid = 1; i_issue_wen = 1; i_issue_rd = 5'd9;
    cyc();
    i_issue_valid = 0;
    i_exu_valid = 1; i_exu_wen = 1; i_exu_waddr = 5'd9; i_exu_wdata = 32'h9999;
    cyc();
    i_exu_valid = 0;
    i_issue_valid = 1;
    settle();
    chk("t5_rf_wen", {31'd0, o_rf_wen}, 32'd1);
    chk("t5_issue_ok", {31'd0, o_issue_ready}, 32'd1);
    adv();
    i_issue_wen = 0; i_issue_rd = '0; i_issue_rs1 = 5'd9;
    settle();
    chk("t5_still_busy", {31'd0, o_issue_ready}, 32'd0);
    adv();

    // x0 write accepted but suppressed; reset drops an accepted entry
    do_reset();
    i_lsu_valid = 1; i_lsu_wen = 1; i_lsu_waddr = '0; i_lsu_wdata = 32'h1234;
    settle();
    chk("t6_lsu_gnt", {31'd0, o_lsu_ready}, 32'd1);
    adv();
    i_lsu_wdata = 32'h5678;
    i_reset = 1;
    settle();
    chk("t6_x0_valid", {31'd0, o_rf_valid}, 32'd1);
    chk("t6_x0_wen", {31'd0, o_rf_wen}, 32'd0);
    chk("t6_x0_wdata", o_rf_wdata, 32'h1234);
    adv();
    i_reset = 0;
    i_lsu_valid = 0;
    settle();
    chk("t6_reset_drop", {31'd0, o_rf_valid}, 32'd0);
    adv();

    // Random traffic; writebacks only retire registers that were issued
    for (int n = 0; n < 600; n++) begin
      if (!exu_h) gen(exu_h, exu_r);
      if (!lsu_h) gen(lsu_h, lsu_r);
      i_exu_valid = exu_h; i_exu_wen = exu_r.wen; i_exu_waddr = exu_r.waddr; i_exu_wdata = exu_r.wdata;
      i_lsu_valid = lsu_h; i_lsu_wen = lsu_r.wen; i_lsu_waddr = lsu_r.waddr; i_lsu_wdata = lsu_r.wdata;
      i_issue_valid = 1'($urandom_range(0, 1));
      i_issue_wen   = 1'($urandom_range(0, 1));
      i_issue_rd    = AW'($urandom_range(0, 7));
      i_issue_rs1   = AW'($urandom_range(0, 7));
      i_issue_rs2   = AW'($urandom_range(0, 7));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
